// File: rtl/sort_seq_ctrl.sv
// Sequencer for the serial FRAME_LEN-element sort unit: streams a frame in,
// waits out the sort latency, captures the result and streams it back out.
module sort_seq_ctrl #(
  parameter int INT_WIDTH = 8,
  parameter int FRAME_LEN = 5,
  parameter int SORT_LAT  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INT_WIDTH-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [INT_WIDTH-1:0] out_data,
  output logic                 out_last,
  output logic                 s_rst,
  output logic [1:0]           s_cmd,
  output logic [INT_WIDTH-1:0] s_data,
  input  logic [INT_WIDTH-1:0] s_result,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam int WW = $clog2(SORT_LAT + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);
  localparam logic [WW-1:0] WAIT_END = WW'(SORT_LAT - 1);

  localparam logic [1:0] CMD_IDLE    = 2'b00;
  localparam logic [1:0] CMD_PUSH    = 2'b01;
  localparam logic [1:0] CMD_CAPTURE = 2'b10;
  localparam logic [1:0] CMD_ADVANCE = 2'b11;

  typedef enum logic [2:0] {
    S_CLEAR,
    S_LOAD,
    S_WAIT,
    S_CAPTURE,
    S_PRIME,
    S_DRAIN
  } state_t;

  state_t          state;
  logic [CW-1:0]   in_cnt;
  logic [CW-1:0]   out_idx;
  logic [WW-1:0]   wait_cnt;
  logic            in_rdy_q;
  logic            out_vld_q;
  logic            s_rst_q;

  logic            in_fire;
  logic            out_fire;
  logic            is_last;

  assign in_fire  = in_valid & in_rdy_q;
  assign out_fire = out_vld_q & out_ready;
  assign is_last  = (out_idx == LAST_IDX);

  assign in_ready   = in_rdy_q;
  assign out_valid  = out_vld_q;
  assign out_data   = s_result;
  assign out_last   = out_vld_q & is_last;
  assign s_rst      = s_rst_q;
  assign s_data     = in_data;
  assign frame_done = out_fire & is_last;
  assign busy       = !((state == S_LOAD) && (in_cnt == '0));

  // The last element is not followed by an advance; the sort unit is reset instead.
  always_comb begin
    s_cmd = CMD_IDLE;
    if (in_fire)
      s_cmd = CMD_PUSH;
    else if (state == S_CAPTURE)
      s_cmd = CMD_CAPTURE;
    else if (state == S_PRIME)
      s_cmd = CMD_ADVANCE;
    else if (out_fire && !is_last)
      s_cmd = CMD_ADVANCE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_CLEAR;
      in_cnt    <= '0;
      out_idx   <= '0;
      wait_cnt  <= '0;
      in_rdy_q  <= 1'b0;
      out_vld_q <= 1'b0;
      s_rst_q   <= 1'b1;
    end else begin
      case (state)
        S_CLEAR: begin
          s_rst_q  <= 1'b0;
          in_cnt   <= '0;
          out_idx  <= '0;
          wait_cnt <= '0;
          in_rdy_q <= 1'b1;
          state    <= S_LOAD;
        end
        S_LOAD: begin
          if (in_fire) begin
            in_cnt <= in_cnt + CW'(1);
            if (in_cnt == LAST_IDX) begin
              in_rdy_q <= 1'b0;
              wait_cnt <= '0;
              state    <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt == WAIT_END)
            state <= S_CAPTURE;
          else
            wait_cnt <= wait_cnt + WW'(1);
        end
        S_CAPTURE: begin
          state <= S_PRIME;
        end
        S_PRIME: begin
          out_idx   <= '0;
          out_vld_q <= 1'b1;
          state     <= S_DRAIN;
        end
        S_DRAIN: begin
          if (out_fire) begin
            if (is_last) begin
              out_vld_q <= 1'b0;
              s_rst_q   <= 1'b1;
              state     <= S_CLEAR;
            end else begin
              out_idx <= out_idx + CW'(1);
            end
          end
        end
        default: begin
          in_rdy_q  <= 1'b0;
          out_vld_q <= 1'b0;
          s_rst_q   <= 1'b1;
          state     <= S_CLEAR;
        end
      endcase
    end
  end

endmodule
